// File: rtl/ifd_protocol_monitor.sv
// Passive fetch/decode protocol monitor for the IFD memory and IFD->EX busses.
// Six rules are checked each cycle; results feed sticky flags, saturating counters, a violation log and opcode coverage.
module ifd_protocol_monitor #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int START_ADDR = 'o200,
  parameter int RD_LAT     = 1,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int LOG_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clr,
  input  logic                      ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0]     ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0]     ifu_rd_data,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [5:0]                mem_op,
  input  logic [DATA_WIDTH-4:0]     mem_addr,
  input  logic [21:0]               op7_op,
  input  logic                      stall,
  output logic [5:0]                err_flags,
  output logic                      err_any,
  output logic [6*CNT_WIDTH-1:0]    err_count,
  output logic                      log_valid,
  output logic [2:0]                log_rule,
  output logic [ADDR_WIDTH-1:0]     log_addr,
  input  logic                      log_pop,
  output logic                      log_ovf,
  output logic [27:0]               cov_hit,
  output logic                      cov_all
);
  localparam int LPW = $clog2(LOG_DEPTH);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int EW  = 3 + ADDR_WIDTH;

  // Operate-group encodings, indexed by op7_op bit position.
  function automatic logic [11:0] op7_code(input int idx);
    case (idx)
      0:  return 12'o7000;  1:  return 12'o7001;  2:  return 12'o7004;
      3:  return 12'o7006;  4:  return 12'o7010;  5:  return 12'o7012;
      6:  return 12'o7020;  7:  return 12'o7040;  8:  return 12'o7100;
      9:  return 12'o7200;  10: return 12'o7402;  11: return 12'o7404;
      12: return 12'o7410;  13: return 12'o7420;  14: return 12'o7430;
      15: return 12'o7440;  16: return 12'o7450;  17: return 12'o7500;
      18: return 12'o7510;  19: return 12'o7002;  20: return 12'o7041;
      21: return 12'o7600;
      default: return 12'o0000;
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                  req_q, act_q, pending_q, first_q, ovf_q;
  logic [TW-1:0]         tmo_q;
  logic [RD_LAT-1:0]     lat_q;
  logic [ADDR_WIDTH-1:0] fetch_addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [5:0]            flags_q;
  logic [CNT_WIDTH-1:0]  cnt_q [6];
  logic [LPW:0]          wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]         log_mem_q [LOG_DEPTH];
  logic [27:0]           cov_q;

  logic [27:0] dec_vec;
  logic        req_edge, act, instr_ev, onehot, dec_err;
  logic [5:0]  fire;
  logic [2:0]  push_rule;
  logic        log_full, push, pop_ok, push_ok;
  logic [EW-1:0] head;

  assign dec_vec  = {mem_op, op7_op};
  assign req_edge = ifu_rd_req & ~req_q;
  assign act      = |dec_vec;
  assign instr_ev = act & ~act_q;
  assign onehot   = ($countones(dec_vec) == 1);

  // NOP (op7 bit 0) has no fixed encoding requirement, so its check is skipped.
  always_comb begin
    dec_err = 1'b0;
    for (int i = 0; i < 6; i++)
      if (mem_op[i] && ((data_q[DATA_WIDTH-1 -: 3] != 3'(i)) ||
                        (mem_addr != data_q[DATA_WIDTH-4:0])))
        dec_err = 1'b1;
    for (int i = 1; i < 22; i++)
      if (op7_op[i] && (data_q != DATA_WIDTH'(op7_code(i))))
        dec_err = 1'b1;
  end

  always_comb begin
    fire[0] = req_edge & act;
    fire[1] = instr_ev & first_q & (base_addr != ADDR_WIDTH'(START_ADDR));
    fire[2] = instr_ev & ~onehot;
    fire[3] = instr_ev & onehot & dec_err;
    fire[4] = pending_q & ~instr_ev & ~stall & (tmo_q == TW'(TIMEOUT - 1));
    fire[5] = instr_ev & ~pending_q;
    push_rule = '0;
    for (int r = 5; r >= 0; r--)
      if (fire[r]) push_rule = 3'(r);
  end

  assign log_valid = (wr_ptr_q != rd_ptr_q);
  assign log_full  = ((wr_ptr_q - rd_ptr_q) == (LPW+1)'(LOG_DEPTH));
  assign pop_ok    = log_pop & log_valid;
  assign push      = |fire;
  assign push_ok   = push & (~log_full | pop_ok);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q     <= 1'b0;
      act_q     <= 1'b0;
      pending_q <= 1'b0;
      first_q   <= 1'b1;
      tmo_q     <= '0;
      lat_q     <= '0;
      flags_q   <= '0;
      for (int r = 0; r < 6; r++) cnt_q[r] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      cov_q     <= '0;
    end else begin
      req_q  <= ifu_rd_req;
      act_q  <= act;
      lat_q[0] <= req_edge;
      for (int k = 1; k < RD_LAT; k++) lat_q[k] <= lat_q[k-1];
      if (instr_ev) first_q <= 1'b0;
      // A new fetch restarts tracking even if the previous one is still open.
      if (req_edge) begin
        pending_q <= 1'b1;
        tmo_q     <= '0;
      end else if (instr_ev || fire[4]) begin
        pending_q <= 1'b0;
      end else if (pending_q && !stall) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (clr) begin
        flags_q  <= '0;
        for (int r = 0; r < 6; r++) cnt_q[r] <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ovf_q    <= 1'b0;
        cov_q    <= '0;
      end else begin
        flags_q <= flags_q | fire;
        for (int r = 0; r < 6; r++)
          if (fire[r]) cnt_q[r] <= sat_inc(cnt_q[r]);
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        else if (push) ovf_q <= 1'b1;
        if (instr_ev && onehot && !dec_err) cov_q <= cov_q | dec_vec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_edge) fetch_addr_q <= ifu_rd_addr;
    if (lat_q[RD_LAT-1]) data_q <= ifu_rd_data;
    if (push_ok && !clr) log_mem_q[wr_ptr_q[LPW-1:0]] <= {push_rule, fetch_addr_q};
  end

  assign head      = log_mem_q[rd_ptr_q[LPW-1:0]];
  assign log_rule  = log_valid ? head[EW-1 -: 3] : '0;
  assign log_addr  = log_valid ? head[ADDR_WIDTH-1:0] : '0;
  assign err_flags = flags_q;
  assign err_any   = |flags_q;
  assign log_ovf   = ovf_q;
  assign cov_hit   = cov_q;
  assign cov_all   = &cov_q;

  always_comb begin
    err_count = '0;
    for (int r = 0; r < 6; r++) err_count[r*CNT_WIDTH +: CNT_WIDTH] = cnt_q[r];
  end

endmodule
